// File: rtl/vertex_buffer_source.sv
// rtl/vertex_buffer_source.sv - per-frame triangle ROM streamer with FWFT pop/empty output
// Two-entry output buffer plus one ROM read in flight keeps pop-every-cycle bubble free.
module vertex_buffer_source #(
    parameter int TRI_COUNT = 64,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 224
) (
    input  logic              clk100,
    input  logic              rst,
    input  logic              nextFrame,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] VertexBuffer_PreCalc_ReadData,
    input  logic              VertexBuffer_PreCalc_pop,
    output logic              VertexBuffer_PreCalc_empty,
    output logic              frame_done
);
    localparam logic [ADDR_W:0] TC = (ADDR_W + 1)'(TRI_COUNT);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   issue_cnt_q, issue_cnt_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [DATA_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [1:0]        occ_q, occ_d;
    logic              inflight_q, inflight_d;
    logic              empty_q;
    logic              done_q, done_d;
    logic              pop_ok, issue;
    logic [2:0]        credit;

    always_comb begin
        pop_ok = VertexBuffer_PreCalc_pop && (occ_q != 2'd0) && !nextFrame;
        // A pop at this edge frees a slot, so it counts toward the credit.
        credit = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop_ok};
        issue  = (state_q == FETCH) && (issue_cnt_q < TC) && (credit < 3'd2) && !nextFrame;

        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        rom_addr_d  = rom_addr_q;
        head_d      = head_q;
        tail_d      = tail_q;
        occ_d       = occ_q;
        inflight_d  = issue;
        done_d      = 1'b0;

        case ({pop_ok, inflight_q})
            2'b01: begin
                if (occ_q == 2'd0) head_d = rom_data;
                else               tail_d = rom_data;
                occ_d = occ_q + 2'd1;
            end
            2'b10: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    head_d = rom_data;
                end else begin
                    head_d = tail_q;
                    tail_d = rom_data;
                end
            end
            default: ;
        endcase

        // rom_addr parks on the final address instead of wrapping.
        if (issue) begin
            issue_cnt_d = issue_cnt_q + 1'b1;
            if ((issue_cnt_q + 1'b1) < TC) rom_addr_d = rom_addr_q + 1'b1;
        end

        case (state_q)
            FETCH: if (issue_cnt_d == TC) state_d = DRAIN;
            DRAIN: begin
                if (occ_q == 2'd0 && !inflight_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: ;
        endcase

        if (nextFrame) begin
            occ_d       = 2'd0;
            inflight_d  = 1'b0;
            issue_cnt_d = '0;
            rom_addr_d  = '0;
            done_d      = (TC == '0);
            state_d     = (TC == '0) ? IDLE : FETCH;
        end
    end

    always_ff @(posedge clk100) begin
        if (rst) begin
            state_q     <= IDLE;
            issue_cnt_q <= '0;
            rom_addr_q  <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            occ_q       <= 2'd0;
            inflight_q  <= 1'b0;
            empty_q     <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            rom_addr_q  <= rom_addr_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            occ_q       <= occ_d;
            inflight_q  <= inflight_d;
            empty_q     <= (occ_d == 2'd0);
            done_q      <= done_d;
        end
    end

    assign rom_addr                      = rom_addr_q;
    assign VertexBuffer_PreCalc_ReadData = head_q;
    assign VertexBuffer_PreCalc_empty    = empty_q;
    assign frame_done                    = done_q;
endmodule

// File: tb/tb_vertex_buffer_source.sv
// tb/tb_vertex_buffer_source.sv - self-checking bench for vertex_buffer_source
// Four instances (TRI_COUNT 4, 8, 0, 256) share clock and reset; each has its own ROM.
module tb_vertex_buffer_source;
    logic         clk100 = 1'b0;
    logic         rst;
    logic         nf     [4];
    logic         pop    [4];
    logic [7:0]   raddr  [4];
    logic [223:0] rdata  [4];
    logic         empty  [4];
    logic         fdone  [4];

    int errors = 0;
    int checks = 0;
    int fd_cnt [4];

    always #5 clk100 = ~clk100;

    function automatic logic [223:0] rec(input int i);
        logic [223:0] r;
        for (int j = 0; j < 7; j++) r[j*32 +: 32] = 32'(i) * 32'h9E37_79B1 + 32'(j) + 32'h0000_1000;
        return r;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int TCV = (g == 0) ? 4 : (g == 1) ? 8 : (g == 2) ? 0 : 256;
        logic [223:0] romd;

        always_ff @(posedge clk100) romd <= rec(int'(raddr[g]));

        vertex_buffer_source #(.TRI_COUNT(TCV), .ADDR_W(8), .DATA_W(224)) u_dut (
            .clk100                        (clk100),
            .rst                           (rst),
            .nextFrame                     (nf[g]),
            .rom_addr                      (raddr[g]),
            .rom_data                      (romd),
            .VertexBuffer_PreCalc_ReadData (rdata[g]),
            .VertexBuffer_PreCalc_pop      (pop[g]),
            .VertexBuffer_PreCalc_empty    (empty[g]),
            .frame_done                    (fdone[g])
        );
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then sample; every frame_done seen must coincide with empty=1.
    task automatic tick();
        @(posedge clk100);
        #1;
        for (int g = 0; g < 4; g++) begin
            if (fdone[g] === 1'b1) begin
                fd_cnt[g]++;
                chk("fd_while_not_empty", empty[g], 1'b1);
            end
        end
    endtask

    // Reference: a frame is records 0..tc-1 in order, each popped exactly once, then one frame_done.
    task automatic drain(input int g, input int tc, input int pct);
        int idx = 0;
        int cyc = 0;
        int fd0 = fd_cnt[g];
        while (idx < tc && cyc < 4000) begin
            pop[g] = ($urandom_range(99) < pct);
            if (pop[g] && empty[g] === 1'b0) begin
                chk("stream_record", rdata[g], rec(idx));
                idx++;
            end
            tick();
            cyc++;
        end
        pop[g] = 1'b0;
        chk("records_popped", idx, tc);
        repeat (4) tick();
        chk("empty_after_frame", empty[g], 1'b1);
        chk("one_frame_done", fd_cnt[g] - fd0, 1);
    endtask

    initial begin
        int fd0;
        rst = 1'b1;
        for (int g = 0; g < 4; g++) begin nf[g] = 1'b0; pop[g] = 1'b0; fd_cnt[g] = 0; end

        repeat (3) begin
            for (int g = 0; g < 4; g++) begin
                nf[g]  = 1'($urandom_range(1));
                pop[g] = 1'($urandom_range(1));
            end
            tick();
        end
        for (int g = 0; g < 4; g++) begin
            chk("rst_empty", empty[g], 1'b1);
            chk("rst_rom_addr", raddr[g], 8'd0);
            chk("rst_frame_done", fdone[g], 1'b0);
            chk("rst_readdata", rdata[g], 224'd0);
        end
        rst = 1'b0;
        for (int g = 0; g < 4; g++) begin nf[g] = 1'b0; pop[g] = 1'b0; end
        tick();
        for (int g = 0; g < 4; g++) fd_cnt[g] = 0;

        // TRI_COUNT=4, pop held: records on consecutive cycles from E2
        pop[0] = 1'b1;
        nf[0]  = 1'b1;
        tick();
        nf[0] = 1'b0;
        chk("lat_e0_empty", empty[0], 1'b1);
        chk("lat_e0_addr", raddr[0], 8'd0);
        tick();
        chk("lat_e1_empty", empty[0], 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("tc4_not_empty", empty[0], 1'b0);
            chk("tc4_record", rdata[0], rec(k));
        end
        tick();
        chk("tc4_empty_after_last", empty[0], 1'b1);
        repeat (3) tick();
        chk("tc4_frame_done_once", fd_cnt[0], 1);
        chk("tc4_addr_holds", raddr[0], 8'd3);
        chk("tc4_pop_on_empty", empty[0], 1'b1);
        pop[0] = 1'b0;

        // Pop while empty on an idle instance changes nothing
        pop[1] = 1'b1;
        tick();
        pop[1] = 1'b0;
        chk("idle_pop_empty", empty[1], 1'b1);
        chk("idle_pop_addr", raddr[1], 8'd0);
        chk("idle_pop_no_done", fd_cnt[1], 0);

        // Backpressure: no pops -> only addresses 0 and 1 issued, head holds record 0
        nf[1] = 1'b1;
        tick();
        nf[1] = 1'b0;
        repeat (6) tick();
        chk("bp_rom_addr", raddr[1], 8'd2);
        chk("bp_not_empty", empty[1], 1'b0);
        chk("bp_head", rdata[1], rec(0));
        drain(1, 8, 60);

        // Mid-frame restart after three pops
        fd0    = fd_cnt[1];
        nf[1]  = 1'b1;
        pop[1] = 1'b1;
        tick();
        nf[1] = 1'b0;
        repeat (5) tick();
        chk("mid_head_before_restart", rdata[1], rec(3));
        pop[1] = 1'b0;
        nf[1]  = 1'b1;
        tick();
        nf[1] = 1'b0;
        chk("mid_restart_empty", empty[1], 1'b1);
        drain(1, 8, 100);
        chk("mid_no_done_for_aborted", fd_cnt[1] - fd0, 1);

        // nextFrame and pop together while data is available
        nf[1] = 1'b1;
        tick();
        nf[1] = 1'b0;
        repeat (3) tick();
        chk("simul_pre_empty", empty[1], 1'b0);
        chk("simul_pre_head", rdata[1], rec(0));
        nf[1]  = 1'b1;
        pop[1] = 1'b1;
        tick();
        nf[1]  = 1'b0;
        pop[1] = 1'b0;
        chk("simul_flush_empty", empty[1], 1'b1);
        drain(1, 8, 50);

        // TRI_COUNT=0: immediate single-cycle frame_done, never any data
        nf[2] = 1'b1;
        tick();
        nf[2] = 1'b0;
        chk("tc0_done_pulse", fdone[2], 1'b1);
        chk("tc0_empty", empty[2], 1'b1);
        tick();
        chk("tc0_done_cleared", fdone[2], 1'b0);
        chk("tc0_empty_stays", empty[2], 1'b1);
        repeat (3) tick();
        chk("tc0_done_count", fd_cnt[2], 1);

        // TRI_COUNT=256, random 50% pops, three frames
        for (int f = 0; f < 3; f++) begin
            nf[3] = 1'b1;
            tick();
            nf[3] = 1'b0;
            drain(3, 256, 50);
        end
        chk("tc256_addr_no_wrap", raddr[3], 8'd255);
        chk("tc256_done_count", fd_cnt[3], 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
